// File: rtl/sweep_counter_ctrl.sv
// sweep_counter_ctrl: runs a bounded up/down counter in ping-pong sweeps
// between latched lo/hi bounds, counts completed sweeps, and reports
// busy/done/err status to the host.
module sweep_counter_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SW_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [SW_W-1:0]  sweeps,
    output logic [WIDTH-1:0] count,
    output logic             up_down,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [SW_W-1:0]  sweep_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StUp,
        StDown,
        StDone
    } state_e;

    localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);
    localparam logic [SW_W-1:0]  SwOne  = SW_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [SW_W-1:0]  sweeps_q, sweeps_d;
    logic [SW_W-1:0]  sweep_cnt_q, sweep_cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [SW_W-1:0]  sweep_inc;

    // State and datapath registers; reset forces idle values immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            sweeps_q    <= '0;
            sweep_cnt_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            sweeps_q    <= sweeps_d;
            sweep_cnt_q <= sweep_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state, counter and pulse logic for the sweep sequencer.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        sweeps_d    = sweeps_q;
        sweep_cnt_d = sweep_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        // Wraps modulo 2^SW_W in continuous mode.
        sweep_inc   = sweep_cnt_q + SwOne;

        unique case (state_q)
            StIdle: begin
                // stop outranks start; a rejected start only raises err.
                if (start && !stop) begin
                    if (lo < hi) begin
                        lo_d        = lo;
                        hi_d        = hi;
                        sweeps_d    = sweeps;
                        count_d     = lo;
                        sweep_cnt_d = '0;
                        state_d     = StUp;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            StUp: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (count_q == hi_q) begin
                    // hi_q is shown for one cycle, then turn around at once.
                    count_d = count_q - CntOne;
                    state_d = StDown;
                end else begin
                    count_d = count_q + CntOne;
                end
            end

            StDown: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (count_q == lo_q) begin
                    sweep_cnt_d = sweep_inc;
                    if ((sweeps_q != '0) && (sweep_inc == sweeps_q)) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        // Skip lo_q on the way back up so it appears only once.
                        count_d = lo_q + CntOne;
                        state_d = StUp;
                    end
                end else begin
                    count_d = count_q - CntOne;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status outputs decoded from state; done/err come straight from registers.
    always_comb begin
        count     = count_q;
        sweep_cnt = sweep_cnt_q;
        done      = done_q;
        err       = err_q;
        busy      = (state_q == StUp) || (state_q == StDown);
        up_down   = (state_q != StDown);
    end

endmodule
